// File: rtl/stream_ready_stall.sv
// Sink-side stream throttle: holds ready low for a fixed or LFSR-driven number of cycles
// per beat, checks source handshake rules and counts completed transfers.
module stream_ready_stall #(
    parameter bit          StallRandom = 1'b0,
    parameter int unsigned FixedStall  = 1,
    parameter int unsigned CntWidth    = 4,
    parameter logic [15:0] LfsrSeed    = 16'hACE1,
    parameter type         payload_t   = logic
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  payload_t    payload_i,
    input  logic        valid_i,
    output logic        ready_o,
    output payload_t    payload_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        protocol_err_o,
    output logic [15:0] xfer_cnt_o
);

    typedef enum logic [1:0] {StIdle, StStall, StOpen} state_e;

    state_e              state_q;
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] stall_n;
    logic [15:0]         lfsr_q;
    logic [15:0]         xfer_q;
    logic                err_q;
    payload_t            payload_q;
    logic                lfsr_fb;
    logic                open_now;
    logic                handshake;
    logic                violation;

    if (LfsrSeed == 16'h0) begin : g_seed_check
        $error("stream_ready_stall: LfsrSeed must be nonzero");
    end

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign stall_n = StallRandom ? lfsr_q[CntWidth-1:0] : CntWidth'(FixedStall);

    // A zero-length stall lets IDLE act as OPEN in the same cycle.
    always_comb begin
        open_now = 1'b0;
        case (state_q)
            StIdle:  open_now = (stall_n == '0);
            StOpen:  open_now = 1'b1;
            default: open_now = 1'b0;
        endcase
        if (rst_i) begin
            open_now = 1'b0;
        end
    end

    assign valid_o        = open_now & valid_i;
    assign ready_o        = open_now & ready_i;
    assign payload_o      = payload_i;
    assign handshake      = valid_i & ready_o;
    assign violation      = (state_q != StIdle) & (!valid_i | (payload_i != payload_q));
    assign protocol_err_o = err_q;
    assign xfer_cnt_o     = xfer_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            lfsr_q    <= LfsrSeed;
            xfer_q    <= '0;
            err_q     <= 1'b0;
            payload_q <= '0;
        end else begin
            if (handshake) begin
                xfer_q <= xfer_q + 16'd1;
            end
            if (violation) begin
                err_q   <= 1'b1;
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (valid_i) begin
                            payload_q <= payload_i;
                            lfsr_q    <= {lfsr_q[14:0], lfsr_fb};
                            if (stall_n == '0) begin
                                state_q <= handshake ? StIdle : StOpen;
                            end else if (stall_n == CntWidth'(1)) begin
                                state_q <= StOpen;
                            end else begin
                                state_q <= StStall;
                                cnt_q   <= stall_n - CntWidth'(2);
                            end
                        end
                    end
                    StStall: begin
                        if (cnt_q == '0) begin
                            state_q <= StOpen;
                        end else begin
                            cnt_q <= cnt_q - CntWidth'(1);
                        end
                    end
                    StOpen: begin
                        if (handshake) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stream_ready_stall.sv
// Bench for stream_ready_stall: four instances (stall 0, 2, 3, random) driven by
// vector tables, hand sequences and a randomized source checked against a beat-level model.
module tb_stream_ready_stall;

    logic       clk;
    logic       rst;
    logic [7:0] pl_in [4];
    logic       v_in  [4];
    logic       rd_in [4];
    logic       rdy_o [4];
    logic [7:0] pl_o  [4];
    logic       vo    [4];
    logic       err   [4];
    logic [15:0] xc   [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v;
        logic [7:0] pl;
        logic       rd;
        logic       er;
        logic       ev;
    } vec_t;
    vec_t vecs [9];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned Fs = (g == 0) ? 0 : (g == 2) ? 3 : 2;
        stream_ready_stall #(
            .StallRandom (g == 3),
            .FixedStall  (Fs),
            .CntWidth    (4),
            .LfsrSeed    (16'hACE1),
            .payload_t   (logic [7:0])
        ) u_dut (
            .clk_i          (clk),
            .rst_i          (rst),
            .payload_i      (pl_in[g]),
            .valid_i        (v_in[g]),
            .ready_o        (rdy_o[g]),
            .payload_o      (pl_o[g]),
            .valid_o        (vo[g]),
            .ready_i        (rd_in[g]),
            .protocol_err_o (err[g]),
            .xfer_cnt_o     (xc[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], ^(x & 16'hB400)};
    endfunction

    // Outputs must be quiet during reset even with both handshake inputs high.
    task automatic do_reset();
        for (int k = 0; k < 4; k++) begin
            v_in[k]  = 1'b1;
            rd_in[k] = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rst_ready", 32'(rdy_o[k]), 0);
            chk("rst_valid", 32'(vo[k]), 0);
        end
        next();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v_in[k]  = 1'b0;
            rd_in[k] = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rst_err", 32'(err[k]), 0);
            chk("rst_xfer", 32'(xc[k]), 0);
        end
        next();
    endtask

    // Beat-level model: ready opens once N cycles have elapsed since the beat's first valid cycle.
    task automatic run_random(input int k, input int beats, input bit rnd, input int fixed_n);
        logic [15:0] lfsr  = 16'hACE1;
        logic [15:0] xfers = '0;
        int          since = 0;
        int          n     = 0;
        int          done  = 0;
        int          cyc   = 0;
        int          peek;
        bit          active = 1'b0;
        bit          open;
        do_reset();
        while (done < beats && cyc < 20000) begin
            peek = rnd ? int'(lfsr[3:0]) : fixed_n;
            if (!active && $urandom_range(0, 3) != 0) begin
                active    = 1'b1;
                since     = 0;
                n         = peek;
                pl_in[k]  = 8'($urandom);
                if (rnd) lfsr = lfsr_next(lfsr);
            end
            v_in[k]  = active;
            rd_in[k] = ($urandom_range(0, 2) != 0);
            open     = active ? (since >= n) : (peek == 0);
            @(negedge clk);
            chk("rnd_ready", 32'(rdy_o[k]), 32'(open & rd_in[k]));
            chk("rnd_valid", 32'(vo[k]), 32'(open & active));
            chk("rnd_payload", 32'(pl_o[k]), 32'(pl_in[k]));
            chk("rnd_err", 32'(err[k]), 0);
            chk("rnd_xfer", 32'(xc[k]), 32'(xfers));
            if (active && open && rd_in[k]) begin
                active = 1'b0;
                xfers  = xfers + 16'd1;
                done++;
            end else if (active) begin
                since++;
            end
            cyc++;
            next();
        end
        chk("rnd_beats", done, beats);
        v_in[k] = 1'b0;
    endtask

    initial begin
        // Stall 2 instance: two stall cycles, then 5 backpressured OPEN cycles, then handshake.
        vecs[0] = '{v: 1'b1, pl: 8'h5A, rd: 1'b0, er: 1'b0, ev: 1'b0};
        vecs[1] = '{v: 1'b1, pl: 8'h5A, rd: 1'b1, er: 1'b0, ev: 1'b0};
        for (int i = 2; i < 7; i++) vecs[i] = '{v: 1'b1, pl: 8'h5A, rd: 1'b0, er: 1'b0, ev: 1'b1};
        vecs[7] = '{v: 1'b1, pl: 8'h5A, rd: 1'b1, er: 1'b1, ev: 1'b1};
        vecs[8] = '{v: 1'b0, pl: 8'h00, rd: 1'b1, er: 1'b0, ev: 1'b0};

        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v_in[k]  = 1'b0;
            rd_in[k] = 1'b0;
            pl_in[k] = 8'h00;
        end

        // Zero stall: one beat per cycle.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            v_in[0]  = 1'b1;
            rd_in[0] = 1'b1;
            pl_in[0] = 8'(i * 17);
            @(negedge clk);
            chk("t1_ready", 32'(rdy_o[0]), 1);
            chk("t1_valid", 32'(vo[0]), 1);
            next();
        end
        v_in[0] = 1'b0;
        @(negedge clk);
        chk("t1_xfer", 32'(xc[0]), 8);
        chk("t1_err", 32'(err[0]), 0);
        next();

        // Vector table with downstream backpressure.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            v_in[1]  = vecs[i].v;
            pl_in[1] = vecs[i].pl;
            rd_in[1] = vecs[i].rd;
            @(negedge clk);
            chk("t3_ready", 32'(rdy_o[1]), 32'(vecs[i].er));
            chk("t3_valid", 32'(vo[1]), 32'(vecs[i].ev));
            next();
        end
        @(negedge clk);
        chk("t3_xfer", 32'(xc[1]), 1);
        chk("t3_err", 32'(err[1]), 0);
        next();

        // valid dropped during STALL: sticky error, fresh full stall afterwards.
        do_reset();
        v_in[1] = 1'b1; pl_in[1] = 8'h33; rd_in[1] = 1'b1;
        next();
        v_in[1] = 1'b0;
        @(negedge clk);
        chk("t4_err_early", 32'(err[1]), 0);
        next();
        v_in[1] = 1'b1; pl_in[1] = 8'h44;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_err", 32'(err[1]), 1);
            chk("t4_ready", 32'(rdy_o[1]), (i == 2) ? 1 : 0);
            next();
        end
        v_in[1] = 1'b0;
        repeat (3) next();
        @(negedge clk);
        chk("t4_err_sticky", 32'(err[1]), 1);
        chk("t4_xfer", 32'(xc[1]), 1);
        next();

        // Stall 3 with valid held: ready 0,0,0,1 repeating, then reset inside a stall.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            v_in[2] = 1'b1; rd_in[2] = 1'b1; pl_in[2] = 8'hC3;
            @(negedge clk);
            chk("t2_ready", 32'(rdy_o[2]), (i % 4 == 3) ? 1 : 0);
            chk("t2_valid", 32'(vo[2]), (i % 4 == 3) ? 1 : 0);
            next();
        end
        @(negedge clk);
        chk("t2_xfer", 32'(xc[2]), 4);
        next();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            v_in[2] = 1'b1; rd_in[2] = 1'b1; pl_in[2] = 8'h3C;
            @(negedge clk);
            chk("t6_ready", 32'(rdy_o[2]), (i == 3) ? 1 : 0);
            next();
        end
        v_in[2] = 1'b0;
        @(negedge clk);
        chk("t6_xfer", 32'(xc[2]), 1);
        next();

        // Randomized runs; the second random run checks the LFSR reseeds on reset.
        run_random(3, 200, 1'b1, 0);
        run_random(3, 60, 1'b1, 0);
        run_random(2, 80, 1'b0, 3);
        run_random(0, 80, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
